// File: rtl/hack_rom_loader_pkg.sv
// Shared definitions for the framed UART-to-ROM loader.
// Contents: protocol byte values, frame-FSM and handshake-FSM state encodings,
// and a helper that tells whether a frame state lies inside an active frame.
package hack_rom_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHECK   = 3'd5,
    REPLY   = 3'd6,
    RUN     = 3'd7
  } frame_state_t;

  typedef enum logic {
    HS_IDLE     = 1'b0,
    HS_WAIT_ACK = 1'b1
  } hs_state_t;

  // States between the sync byte and the checksum byte: the inter-byte
  // timeout and the running checksum are only live here.
  function automatic logic frame_active(input frame_state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHECK);
  endfunction

endpackage

// File: rtl/rom_loader_word_handshake.sv
// Per-word handshake into the hack_soc ROM loader port.
// Holds one completed word, drives it out with a strobe and waits for the
// acknowledge, counting words that were written.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clear             one-cycle: zero words_loaded (start of a new frame)
//   word_valid        one-cycle: word_in is a completed word
//   word_in           completed instruction word
//   rom_loader_ack    hack_soc word-written acknowledge
//   rom_loader_sck    word strobe (high while waiting for ack)
//   rom_loader_data   word being written, stable while sck is high
//   idle              no word pending and no handshake in flight
//   overrun           one-cycle: a word arrived with the holding register full
//   words_loaded      saturating count of acknowledged words
module rom_loader_word_handshake
  import hack_rom_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  rom_loader_ack,
  output logic                  rom_loader_sck,
  output logic [WORD_WIDTH-1:0] rom_loader_data,
  output logic                  idle,
  output logic                  overrun,
  output logic [15:0]           words_loaded
);

  hs_state_t             state_reg, state_next;
  logic                  pending_reg, pending_next;
  logic [WORD_WIDTH-1:0] hold_reg, hold_next;
  logic                  sck_reg, sck_next;
  logic [WORD_WIDTH-1:0] data_reg, data_next;
  logic [15:0]           count_reg, count_next;
  logic                  consume;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= HS_IDLE;
      pending_reg <= 1'b0;
      hold_reg    <= '0;
      sck_reg     <= 1'b0;
      data_reg    <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      hold_reg    <= hold_next;
      sck_reg     <= sck_next;
      data_reg    <= data_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    hold_next    = hold_reg;
    sck_next     = sck_reg;
    data_next    = data_reg;
    count_next   = count_reg;
    consume      = 1'b0;
    overrun      = 1'b0;

    case (state_reg)
      HS_IDLE: begin
        if (pending_reg) begin
          data_next  = hold_reg;
          sck_next   = 1'b1;
          consume    = 1'b1;
          state_next = HS_WAIT_ACK;
        end
      end
      HS_WAIT_ACK: begin
        if (rom_loader_ack) begin
          sck_next = 1'b0;
          if (count_reg != 16'hFFFF) count_next = count_reg + 16'd1;
          state_next = HS_IDLE;
        end
      end
      default: state_next = HS_IDLE;
    endcase

    if (consume) pending_next = 1'b0;

    // A word arriving in the same cycle the held word moves to the output
    // register still fits; only a genuinely full holding register drops it.
    if (word_valid) begin
      if (pending_reg && !consume) begin
        overrun = 1'b1;
      end else begin
        hold_next    = word_in;
        pending_next = 1'b1;
      end
    end

    if (clear) count_next = '0;
  end

  assign rom_loader_sck  = sck_reg;
  assign rom_loader_data = data_reg;
  assign words_loaded    = count_reg;
  assign idle            = (state_reg == HS_IDLE) && !pending_reg;

endmodule

// File: rtl/uart_rom_frame_loader.sv
// Framed serial-to-ROM loader for hack_soc.
// Frame: A5, count[15:8], count[7:0], count x {hi, lo} words, checksum.
// The 8-bit sum of every byte after the sync byte (checksum included) must be
// zero. A verified frame releases rom_loader_load; a failed one gets a NAK
// and a one-cycle low pulse on rom_loader_load to restart the ROM address.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   rx_valid, rx_byte               received byte strobe and value
//   tx_busy, tx_start, tx_byte      UART transmitter interface (status byte)
//   reload                          pulse: leave RUN and accept a new image
//   rom_loader_load/sck/data/ack    hack_soc ROM loading port
//   done, error, words_loaded       status
module uart_rom_frame_loader
  import hack_rom_loader_pkg::*;
#(
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TIMEOUT_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  input  logic                  reload,
  output logic                  rom_loader_load,
  output logic                  rom_loader_sck,
  output logic [WORD_WIDTH-1:0] rom_loader_data,
  input  logic                  rom_loader_ack,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  frame_state_t             state_reg, state_next;
  logic [15:0]              count_reg, count_next;
  logic [7:0]               hi_reg, hi_next;
  logic [7:0]               csum_reg, csum_next;
  logic [TIMEOUT_WIDTH-1:0] tmo_reg, tmo_next;
  logic                     tx_start_reg, tx_start_next;
  logic [7:0]               tx_byte_reg, tx_byte_next;
  logic                     load_reg, load_next;
  logic                     done_reg, done_next;
  logic                     error_reg, error_next;

  logic                     in_frame;
  logic                     timeout;
  logic                     word_valid;
  logic [WORD_WIDTH-1:0]    word_data;
  logic                     hs_clear;
  logic                     hs_idle;
  logic                     overrun;

  rom_loader_word_handshake #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_handshake (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (hs_clear),
    .word_valid     (word_valid),
    .word_in        (word_data),
    .rom_loader_ack (rom_loader_ack),
    .rom_loader_sck (rom_loader_sck),
    .rom_loader_data(rom_loader_data),
    .idle           (hs_idle),
    .overrun        (overrun),
    .words_loaded   (words_loaded)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= SYNC;
      count_reg    <= '0;
      hi_reg       <= '0;
      csum_reg     <= '0;
      tmo_reg      <= '0;
      tx_start_reg <= 1'b0;
      tx_byte_reg  <= '0;
      load_reg     <= 1'b1;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      hi_reg       <= hi_next;
      csum_reg     <= csum_next;
      tmo_reg      <= tmo_next;
      tx_start_reg <= tx_start_next;
      tx_byte_reg  <= tx_byte_next;
      load_reg     <= load_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    hi_next       = hi_reg;
    csum_next     = csum_reg;
    tx_start_next = 1'b0;
    tx_byte_next  = tx_byte_reg;
    load_next     = load_reg;
    done_next     = done_reg;
    error_next    = error_reg;
    word_valid    = 1'b0;
    word_data     = {hi_reg, rx_byte};
    hs_clear      = 1'b0;

    in_frame = frame_active(state_reg);
    // A byte arriving on the expiry cycle wins: it clears the counter.
    timeout  = in_frame && !rx_valid &&
               (tmo_reg == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    tmo_next = (in_frame && !rx_valid) ? tmo_reg + 1'b1 : '0;

    if (in_frame && rx_valid) csum_next = csum_reg + rx_byte;

    case (state_reg)
      SYNC: begin
        // Also ends the one-cycle low pulse after a NAK.
        load_next = 1'b1;
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          csum_next  = '0;
          error_next = 1'b0;
          hs_clear   = 1'b1;
          state_next = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          count_next[15:8] = rx_byte;
          state_next       = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          count_next[7:0] = rx_byte;
          state_next      = ({count_reg[15:8], rx_byte} == 16'd0) ? CHECK : DATA_HI;
        end
      end
      DATA_HI: begin
        if (rx_valid) begin
          hi_next    = rx_byte;
          state_next = DATA_LO;
        end
      end
      DATA_LO: begin
        if (rx_valid) begin
          word_valid = 1'b1;
          count_next = count_reg - 16'd1;
          state_next = (count_reg > 16'd1) ? DATA_HI : CHECK;
        end
      end
      CHECK: begin
        if (rx_valid) state_next = REPLY;
      end
      REPLY: begin
        // Every accepted word finishes its handshake before the status goes out.
        if (hs_idle && !tx_busy) begin
          tx_start_next = 1'b1;
          if (csum_reg == 8'h00 && !error_reg) begin
            tx_byte_next = ACK_BYTE;
            state_next   = RUN;
          end else begin
            tx_byte_next = NAK_BYTE;
            error_next   = 1'b1;
            load_next    = 1'b0;
            state_next   = SYNC;
          end
        end
      end
      RUN: begin
        if (reload) begin
          load_next  = 1'b1;
          done_next  = 1'b0;
          state_next = SYNC;
        end else begin
          load_next = 1'b0;
          done_next = 1'b1;
        end
      end
      default: state_next = SYNC;
    endcase

    if (timeout) begin
      error_next = 1'b1;
      state_next = REPLY;
    end
    if (overrun) error_next = 1'b1;
  end

  assign tx_start        = tx_start_reg;
  assign tx_byte         = tx_byte_reg;
  assign rom_loader_load = load_reg;
  assign done            = done_reg;
  assign error           = error_reg;

endmodule

// File: tb/tb_uart_rom_frame_loader.sv
module tb_uart_rom_frame_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        reload = 1'b0;
  logic        rom_loader_load;
  logic        rom_loader_sck;
  logic [15:0] rom_loader_data;
  logic        rom_loader_ack = 1'b0;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad = 0;

  // Monitor state (written only by the monitor process).
  int          tx_cnt = 0;
  logic [7:0]  tx_last = 8'h00;
  logic [15:0] sck_q[$];
  int          load_low_cnt = 0;
  int          unstable_cnt = 0;
  logic        sck_prev = 1'b0;
  logic [15:0] data_prev = 16'h0000;
  logic        ack_en = 1'b1;

  logic [7:0]  frame_q[$];

  uart_rom_frame_loader #(
    .WORD_WIDTH    (16),
    .TIMEOUT_CYCLES(1000),
    .TIMEOUT_WIDTH (10)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_valid       (rx_valid),
    .rx_byte        (rx_byte),
    .tx_busy        (tx_busy),
    .tx_start       (tx_start),
    .tx_byte        (tx_byte),
    .reload         (reload),
    .rom_loader_load(rom_loader_load),
    .rom_loader_sck (rom_loader_sck),
    .rom_loader_data(rom_loader_data),
    .rom_loader_ack (rom_loader_ack),
    .done           (done),
    .error          (error),
    .words_loaded   (words_loaded)
  );

  always #5 clk = ~clk;

  // Monitor plus hack_soc model: ack follows sck half a cycle later.
  always @(negedge clk) begin
    if (tx_start) begin
      tx_cnt++;
      tx_last = tx_byte;
      $display("tx: byte=%h", tx_byte);
    end
    if (rom_loader_sck && !sck_prev) sck_q.push_back(rom_loader_data);
    if (rom_loader_sck && sck_prev && rom_loader_data !== data_prev) unstable_cnt++;
    if (!rom_loader_load) load_low_cnt++;
    sck_prev  = rom_loader_sck;
    data_prev = rom_loader_data;
    rom_loader_ack = rom_loader_sck && ack_en;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input string name);
    $display("frame %s: %0d bytes", name, frame_q.size());
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i]);
  endtask

  task automatic wait_tx(input int start, input int limit, input string name);
    int n;
    n = 0;
    while (tx_cnt == start && n < limit) begin
      tick(1);
      n++;
    end
    total++;
    if (tx_cnt == start) begin
      bad++;
      $display("FAIL %s_reply: no status byte within %0d cycles, want one", name, limit);
    end
  endtask

  task automatic do_reload();
    @(posedge clk); #1;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte: got %h want 00", tx_byte); end
    total++; if (rom_loader_load !== 1'b1) begin bad++; $display("FAIL rst_load: got %b want 1", rom_loader_load); end
    total++; if (rom_loader_sck !== 1'b0) begin bad++; $display("FAIL rst_sck: got %b want 0", rom_loader_sck); end
    total++; if (rom_loader_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", rom_loader_data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", error); end
    total++; if (words_loaded !== 16'h0000) begin bad++; $display("FAIL rst_words: got %h want 0000", words_loaded); end
    reset_n = 1'b1;
    tick(2);
  endtask

  // 02+12+34+AB+CD = 0x1C0 -> 0xC0, so the checksum byte is 0x40.
  task automatic test_good_frame(input string name);
    int tx0, sq0;
    tx0 = tx_cnt;
    sq0 = sck_q.size();
    frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(name);
    wait_tx(tx0, 200, name);
    total++; if (tx_last !== 8'h06) begin bad++; $display("FAIL %s_status: got %h want 06", name, tx_last); end
    total++; if (sck_q.size() - sq0 !== 2) begin bad++; $display("FAIL %s_sck_count: got %0d want 2", name, sck_q.size() - sq0); end
    else begin
      total++; if (sck_q[sq0] !== 16'h1234) begin bad++; $display("FAIL %s_word0: got %h want 1234", name, sck_q[sq0]); end
      total++; if (sck_q[sq0+1] !== 16'hABCD) begin bad++; $display("FAIL %s_word1: got %h want abcd", name, sck_q[sq0+1]); end
    end
    total++; if (words_loaded !== 16'd2) begin bad++; $display("FAIL %s_words: got %0d want 2", name, words_loaded); end
    total++; if (rom_loader_load !== 1'b0) begin bad++; $display("FAIL %s_load: got %b want 0", name, rom_loader_load); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s_done: got %b want 1", name, done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL %s_error: got %b want 0", name, error); end
  endtask

  task automatic test_reload();
    do_reload();
    total++; if (rom_loader_load !== 1'b1) begin bad++; $display("FAIL reload_load: got %b want 1", rom_loader_load); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reload_done: got %b want 0", done); end
  endtask

  task automatic test_bad_checksum();
    int tx0, sq0, ll0;
    tx0 = tx_cnt;
    sq0 = sck_q.size();
    ll0 = load_low_cnt;
    frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame("bad_csum");
    wait_tx(tx0, 200, "bad_csum");
    tick(3);
    total++; if (tx_last !== 8'h15) begin bad++; $display("FAIL bad_csum_status: got %h want 15", tx_last); end
    total++; if (sck_q.size() - sq0 !== 2) begin bad++; $display("FAIL bad_csum_sck_count: got %0d want 2", sck_q.size() - sq0); end
    total++; if (words_loaded !== 16'd2) begin bad++; $display("FAIL bad_csum_words: got %0d want 2", words_loaded); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL bad_csum_error: got %b want 1", error); end
    total++; if (load_low_cnt - ll0 !== 1) begin bad++; $display("FAIL bad_csum_load_pulse: got %0d low cycles want 1", load_low_cnt - ll0); end
    total++; if (rom_loader_load !== 1'b1) begin bad++; $display("FAIL bad_csum_load_after: got %b want 1", rom_loader_load); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL bad_csum_done: got %b want 0", done); end
  endtask

  // Also checks that the sync byte clears the sticky error and that the reply
  // waits for the transmitter.
  task automatic test_zero_length();
    int tx0, sq0;
    tx0 = tx_cnt;
    sq0 = sck_q.size();
    tx_busy = 1'b1;
    $display("frame zero_len: 4 bytes");
    send_byte(8'hA5);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL sync_clears_error: got %b want 0", error); end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    tick(10);
    total++; if (tx_cnt !== tx0) begin bad++; $display("FAIL zero_busy_hold: got %0d replies want 0", tx_cnt - tx0); end
    tx_busy = 1'b0;
    wait_tx(tx0, 50, "zero_len");
    total++; if (tx_last !== 8'h06) begin bad++; $display("FAIL zero_status: got %h want 06", tx_last); end
    total++; if (sck_q.size() !== sq0) begin bad++; $display("FAIL zero_sck: got %0d strobes want 0", sck_q.size() - sq0); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL zero_words: got %0d want 0", words_loaded); end
  endtask

  task automatic test_timeout();
    int tx0, ll0;
    tx0 = tx_cnt;
    ll0 = load_low_cnt;
    frame_q = {8'hA5, 8'h00, 8'h04, 8'h12};
    send_frame("timeout");
    tick(100);
    total++; if (tx_cnt !== tx0) begin bad++; $display("FAIL timeout_early: got %0d replies want 0", tx_cnt - tx0); end
    wait_tx(tx0, 1500, "timeout");
    tick(2);
    total++; if (tx_last !== 8'h15) begin bad++; $display("FAIL timeout_status: got %h want 15", tx_last); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL timeout_error: got %b want 1", error); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL timeout_words: got %0d want 0", words_loaded); end
    total++; if (load_low_cnt - ll0 !== 1) begin bad++; $display("FAIL timeout_load_pulse: got %0d low cycles want 1", load_low_cnt - ll0); end
  endtask

  // Word 1 stalls in the handshake, word 2 fills the holding register and
  // word 3 is dropped. Sum 00+03+11+11+22+22+33+33 = 0xCF, checksum 0x31.
  task automatic test_overrun();
    int tx0, sq0;
    tx0 = tx_cnt;
    sq0 = sck_q.size();
    ack_en = 1'b0;
    frame_q = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h31};
    send_frame("overrun");
    tick(20);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL overrun_error: got %b want 1", error); end
    total++; if (tx_cnt !== tx0) begin bad++; $display("FAIL overrun_reply_held: got %0d replies want 0", tx_cnt - tx0); end
    total++; if (rom_loader_sck !== 1'b1) begin bad++; $display("FAIL overrun_sck_held: got %b want 1", rom_loader_sck); end
    ack_en = 1'b1;
    wait_tx(tx0, 100, "overrun");
    total++; if (tx_last !== 8'h15) begin bad++; $display("FAIL overrun_status: got %h want 15", tx_last); end
    total++; if (words_loaded !== 16'd2) begin bad++; $display("FAIL overrun_words: got %0d want 2", words_loaded); end
    total++; if (sck_q.size() - sq0 !== 2) begin bad++; $display("FAIL overrun_sck_count: got %0d want 2", sck_q.size() - sq0); end
    else begin
      total++; if (sck_q[sq0] !== 16'h1111) begin bad++; $display("FAIL overrun_word0: got %h want 1111", sck_q[sq0]); end
      total++; if (sck_q[sq0+1] !== 16'h2222) begin bad++; $display("FAIL overrun_word1: got %h want 2222", sck_q[sq0+1]); end
    end
  endtask

  task automatic test_reload_async_reset();
    test_good_frame("pre_reload");
    test_reload();
    test_good_frame("after_reload");
    test_reload();
    ack_en = 1'b0;
    frame_q = {8'hA5, 8'h00, 8'h01, 8'h56, 8'h78};
    send_frame("mid_hs");
    total++; if (rom_loader_sck !== 1'b1) begin bad++; $display("FAIL midhs_sck: got %b want 1", rom_loader_sck); end
    total++; if (rom_loader_data !== 16'h5678) begin bad++; $display("FAIL midhs_data: got %h want 5678", rom_loader_data); end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    total++; if (rom_loader_sck !== 1'b0) begin bad++; $display("FAIL async_sck: got %b want 0", rom_loader_sck); end
    total++; if (rom_loader_load !== 1'b1) begin bad++; $display("FAIL async_load: got %b want 1", rom_loader_load); end
    total++; if (words_loaded !== 16'd0) begin bad++; $display("FAIL async_words: got %0d want 0", words_loaded); end
    ack_en = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_good_frame("good");
    test_reload();
    test_bad_checksum();
    test_zero_length();
    test_reload();
    test_timeout();
    test_overrun();
    test_reload_async_reset();
    total++; if (unstable_cnt !== 0) begin bad++; $display("FAIL data_stable: got %0d changes while sck high want 0", unstable_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
